keccak_result_check: RTL and testbench

Downstream stage of the Keccak-800 hasher. It tracks the nonce of every hash in flight with a tag FIFO and compares each 256-bit digest against a share target through a two-stage pipeline. Winning nonces go into a small result queue that the host-side controller drains with a valid/ack handshake. Upstream protocol faults and dropped results are reported through sticky status.

---
 rtl/keccak_result_check.sv | 208 ++++++++++++++++++++
 tb/tb_keccak_result_check.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_result_check.sv
// -----------------------------------------------------------------------------
// keccak_result_check
//
// Result checker that sits after the Keccak-800 hasher. A tag FIFO keeps the
// nonce of every hash that is in flight, in hasher output order. Each digest
// is compared with the share target over two pipeline stages:
//   stage 1 registers a less-than flag and an equal flag for each 64-bit chunk
//   stage 2 combines those flags MSB chunk first into "hash <= target".
// Winning nonces go into a small result FIFO. The host drains that FIFO with
// a valid/ack handshake. Protocol faults and lost winners are held in sticky
// status outputs until the next clear.
//
// Ports
//   clk             single clock
//   rst_n           asynchronous active-low reset
//   issue           a nonce enters the hasher this cycle
//   issue_nonce     nonce for that hash
//   hash_valid      hasher presents a digest this cycle
//   hash            256-bit digest (unsigned, bit 255 is the MSB)
//   target          256-bit share target, sampled together with hash_valid
//   found_valid     result FIFO is not empty
//   found_nonce     winning nonce at the result FIFO head (0 when empty)
//   found_ack       pops the head while found_valid is high
//   clear           synchronous clear of the sticky flags and drop counter
//   tag_overflow    sticky: issue arrived with the tag FIFO full and no pop
//   tag_underflow   sticky: hash_valid arrived with the tag FIFO empty
//   results_dropped saturating count of winners lost to a full result FIFO
// -----------------------------------------------------------------------------
module keccak_result_check #(
    parameter int NONCE_WIDTH  = 32,
    parameter int TAG_DEPTH    = 32,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue,
    input  logic [NONCE_WIDTH-1:0] issue_nonce,
    input  logic                   hash_valid,
    input  logic [255:0]           hash,
    input  logic [255:0]           target,
    output logic                   found_valid,
    output logic [NONCE_WIDTH-1:0] found_nonce,
    input  logic                   found_ack,
    input  logic                   clear,
    output logic                   tag_overflow,
    output logic                   tag_underflow,
    output logic [7:0]             results_dropped
);

    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam int RES_AW = $clog2(RESULT_DEPTH);
    localparam logic [TAG_AW:0] TAG_ONE = 1;
    localparam logic [RES_AW:0] RES_ONE = 1;

    // ------------------------------------------------------------------
    // Tag FIFO
    // The pointers carry one extra wrap bit, so full and empty can be
    // told apart without a separate occupancy counter.
    // ------------------------------------------------------------------
    logic [NONCE_WIDTH-1:0] tag_mem [TAG_DEPTH];
    logic [TAG_AW:0]        tag_wr_ptr;
    logic [TAG_AW:0]        tag_rd_ptr;
    logic                   tag_empty;
    logic                   tag_full;
    logic                   tag_pop;
    logic                   tag_push;
    logic                   tag_ovf_evt;
    logic                   tag_unf_evt;

    assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
    assign tag_full  = (tag_wr_ptr[TAG_AW] != tag_rd_ptr[TAG_AW]) &&
                       (tag_wr_ptr[TAG_AW-1:0] == tag_rd_ptr[TAG_AW-1:0]);

    // A digest can only consume a tag that already exists. If the FIFO is
    // empty, a push in the same cycle does not satisfy it: the digest is
    // discarded and the new tag stays queued.
    assign tag_pop     = hash_valid & ~tag_empty;
    assign tag_push    = issue & (~tag_full | tag_pop);
    assign tag_ovf_evt = issue & tag_full & ~tag_pop;
    assign tag_unf_evt = hash_valid & tag_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples its inputs from before the edge.
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + TAG_ONE;
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TAG_ONE;
        end
    end

    // NOTE: FIFO storage has no reset. The pointers alone decide what is
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr_ptr[TAG_AW-1:0]] <= issue_nonce;
    end

    // ------------------------------------------------------------------
    // Compare stage 1: per-chunk flags and the popped nonce
    // ------------------------------------------------------------------
    logic                   s1_valid;
    logic [NONCE_WIDTH-1:0] s1_nonce;
    logic [3:0]             s1_lt;
    logic [3:0]             s1_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_nonce <= '0;
            s1_lt    <= '0;
            s1_eq    <= '0;
        end else begin
            s1_valid <= tag_pop;
            if (tag_pop) s1_nonce <= tag_mem[tag_rd_ptr[TAG_AW-1:0]];
            for (int k = 0; k < 4; k++) begin
                s1_lt[k] <= hash[64*k +: 64] <  target[64*k +: 64];
                s1_eq[k] <= hash[64*k +: 64] == target[64*k +: 64];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare stage 2: hash <= target
    // Fold from the LSB chunk upward. Each higher chunk overrides the lower
    // result unless it is equal, so the MSB chunk decides first. If all
    // chunks are equal, the seed value of 1 makes the result true.
    // ------------------------------------------------------------------
    logic success;

    always_comb begin
        // NOTE: assigning the default first means no path can leave success
        // unassigned, which would otherwise infer a latch.
        success = 1'b1;
        for (int k = 0; k < 4; k++) begin
            success = s1_lt[k] | (s1_eq[k] & success);
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [NONCE_WIDTH-1:0] res_mem [RESULT_DEPTH];
    logic [RES_AW:0]        res_wr_ptr;
    logic [RES_AW:0]        res_rd_ptr;
    logic                   res_empty;
    logic                   res_full;
    logic                   res_req;
    logic                   res_push;
    logic                   res_pop;
    logic                   drop_evt;

    assign res_empty = (res_wr_ptr == res_rd_ptr);
    assign res_full  = (res_wr_ptr[RES_AW] != res_rd_ptr[RES_AW]) &&
                       (res_wr_ptr[RES_AW-1:0] == res_rd_ptr[RES_AW-1:0]);

    assign res_req  = s1_valid & success;
    assign res_pop  = ~res_empty & found_ack;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // accepted when the head is being acknowledged.
    assign res_push = res_req & (~res_full | res_pop);
    assign drop_evt = res_req & res_full & ~res_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
        end else begin
            if (res_push) res_wr_ptr <= res_wr_ptr + RES_ONE;
            if (res_pop)  res_rd_ptr <= res_rd_ptr + RES_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (res_push) res_mem[res_wr_ptr[RES_AW-1:0]] <= s1_nonce;
    end

    // Both outputs depend only on registers. The head is masked while the
    // FIFO is empty, so found_nonce reads 0 after reset.
    assign found_valid = ~res_empty;
    assign found_nonce = res_empty ? '0 : res_mem[res_rd_ptr[RES_AW-1:0]];

    // ------------------------------------------------------------------
    // Sticky status. An event in the same cycle as clear takes priority.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_overflow    <= 1'b0;
            tag_underflow   <= 1'b0;
            results_dropped <= '0;
        end else begin
            if (tag_ovf_evt)  tag_overflow <= 1'b1;
            else if (clear)   tag_overflow <= 1'b0;

            if (tag_unf_evt)  tag_underflow <= 1'b1;
            else if (clear)   tag_underflow <= 1'b0;

            if (drop_evt) begin
                if (clear)                         results_dropped <= 8'd1;
                else if (results_dropped != 8'hFF) results_dropped <= results_dropped + 8'd1;
            end else if (clear) begin
                results_dropped <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keccak_result_check.sv
// -----------------------------------------------------------------------------
// tb_keccak_result_check
//
// Self-checking bench for keccak_result_check, built with a 4-entry tag FIFO
// and a 4-entry result FIFO. A small model of the tag FIFO sits beside the
// stimulus. When a digest is driven, the model works out which nonce it
// belongs to and whether hash <= target. Expected winners go into a
// scoreboard queue, and the result handshake pops and compares them.
// Inputs change on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_keccak_result_check;

    localparam int NW        = 32;
    localparam int TAG_D     = 4;
    localparam int RES_D     = 4;
    localparam logic [255:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue;
    logic [NW-1:0] issue_nonce;
    logic          hash_valid;
    logic [255:0]  hash;
    logic [255:0]  target;
    logic          found_valid;
    logic [NW-1:0] found_nonce;
    logic          found_ack;
    logic          clear;
    logic          tag_overflow;
    logic          tag_underflow;
    logic [7:0]    results_dropped;

    always #5 clk = ~clk;

    keccak_result_check #(
        .NONCE_WIDTH (NW),
        .TAG_DEPTH   (TAG_D),
        .RESULT_DEPTH(RES_D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue          (issue),
        .issue_nonce    (issue_nonce),
        .hash_valid     (hash_valid),
        .hash           (hash),
        .target         (target),
        .found_valid    (found_valid),
        .found_nonce    (found_nonce),
        .found_ack      (found_ack),
        .clear          (clear),
        .tag_overflow   (tag_overflow),
        .tag_underflow  (tag_underflow),
        .results_dropped(results_dropped)
    );

    int            checks = 0;
    int            errors = 0;
    logic [NW-1:0] tag_q[$];   // model of the tag FIFO
    logic [NW-1:0] exp_q[$];   // scoreboard of expected winners
    int            exp_drops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one cycle of issue and/or hash_valid, and update the models.
    // The result-FIFO model assumes no ack overlaps the push; the one test
    // that overlaps them adjusts exp_q by hand.
    task automatic drive(input bit iss, input logic [NW-1:0] n, input bit hv, input logic [255:0] h);
        bit            pop_ok;
        logic [NW-1:0] popped;
        pop_ok = hv && (tag_q.size() > 0);
        popped = '0;
        if (pop_ok) popped = tag_q.pop_front();
        if (iss && (tag_q.size() < TAG_D)) tag_q.push_back(n);
        if (pop_ok && (h <= target)) begin
            if (exp_q.size() < RES_D) exp_q.push_back(popped);
            else                      exp_drops++;
        end
        issue       = iss;
        issue_nonce = n;
        hash_valid  = hv;
        hash        = h;
        tick();
        issue      = 1'b0;
        hash_valid = 1'b0;
    endtask

    // Pop the result FIFO until it is empty, one ack per cycle, comparing
    // each head against the scoreboard. The loop is bounded.
    task automatic drain(input string tag);
        int exp_n;
        int n;
        exp_n = exp_q.size();
        n     = 0;
        for (int i = 0; i < RES_D + 4; i++) begin
            if (!found_valid) break;
            if (exp_q.size() == 0) check({tag, "_unexpected"}, 64'(found_valid), 64'd0);
            else                   check({tag, "_nonce"}, 64'(found_nonce), 64'(exp_q.pop_front()));
            n++;
            found_ack = 1'b1;
            tick();
            found_ack = 1'b0;
        end
        check({tag, "_count"}, 64'(n), 64'(exp_n));
        check({tag, "_empty"}, 64'(found_valid), 64'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [NW-1:0] saved;
        int            fv_seen;

        rst_n       = 1'b0;
        issue       = 1'b0;
        issue_nonce = '0;
        hash_valid  = 1'b0;
        hash        = '0;
        target      = '0;
        found_ack   = 1'b0;
        clear       = 1'b0;

        // ---------------- reset state ----------------
        idle(2);
        check("rst_found_valid", 64'(found_valid),     64'd0);
        check("rst_found_nonce", 64'(found_nonce),     64'd0);
        check("rst_overflow",    64'(tag_overflow),    64'd0);
        check("rst_underflow",   64'(tag_underflow),   64'd0);
        check("rst_dropped",     64'(results_dropped), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // ---------------- basic compare, target = 2^224 ----------------
        target = 256'd1 << 224;
        for (int i = 0; i < 4; i++) drive(1'b1, NW'(32'h10 + i), 1'b0, '0);
        drive(1'b0, '0, 1'b1, '0);                    // cycle T: hash = 0
        check("t1_lat_s1", 64'(found_valid), 64'd0);  // only stage 1 at T+1
        drive(1'b0, '0, 1'b1, target);                // hash == target
        check("t1_lat_fv", 64'(found_valid), 64'd1);  // visible in T+2
        check("t1_lat_nonce", 64'(found_nonce), 64'h10);
        drive(1'b0, '0, 1'b1, target + 256'd1);
        drive(1'b0, '0, 1'b1, ONES);
        idle(3);
        drain("t1");

        // ---------------- 64-bit chunk boundary ----------------
        target = 256'd1 << 64;
        drive(1'b1, 32'h20, 1'b0, '0);
        drive(1'b1, 32'h21, 1'b0, '0);
        drive(1'b0, '0, 1'b1, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        drive(1'b0, '0, 1'b1, (256'd1 << 64) + 256'd1);
        idle(3);
        drain("t2");

        // ---------------- overfill the result FIFO at full throughput ----------------
        target = ONES;
        drive(1'b1, 32'h30, 1'b0, '0);
        for (int i = 1; i < 6; i++) drive(1'b1, NW'(32'h30 + i), 1'b1, '0);
        drive(1'b0, '0, 1'b1, '0);
        idle(3);
        check("t3_dropped", 64'(results_dropped), 64'(exp_drops));
        drain("t3");
        pulse_clear();
        exp_drops = 0;
        check("t3_dropped_clr", 64'(results_dropped), 64'd0);

        // ---------------- push into a full FIFO while it pops ----------------
        for (int i = 0; i < 4; i++) drive(1'b1, NW'(32'h40 + i), 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, '0);
        idle(3);
        drive(1'b1, 32'h44, 1'b0, '0);
        saved = exp_q.pop_front();                   // the ack removes this head first
        drive(1'b0, '0, 1'b1, '0);                   // stage 1 holds 0x44 now
        check("t4_full", 64'(found_valid), 64'd1);
        check("t4_head", 64'(found_nonce), 64'(saved));
        found_ack = 1'b1;                            // push and pop on the same edge
        tick();
        found_ack = 1'b0;
        idle(2);
        check("t4_dropped", 64'(results_dropped), 64'd0);
        drain("t4");

        // ---------------- tag overflow / underflow / clear ----------------
        for (int i = 0; i < 4; i++) drive(1'b1, NW'(32'h50 + i), 1'b0, '0);
        check("t5_ovf_before", 64'(tag_overflow), 64'd0);
        drive(1'b1, 32'h54, 1'b0, '0);
        check("t5_ovf", 64'(tag_overflow), 64'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, '0);
        idle(3);
        drain("t5");
        check("t5_unf_before", 64'(tag_underflow), 64'd0);
        drive(1'b0, '0, 1'b1, '0);
        check("t5_unf", 64'(tag_underflow), 64'd1);
        pulse_clear();
        check("t5_ovf_clr", 64'(tag_overflow),  64'd0);
        check("t5_unf_clr", 64'(tag_underflow), 64'd0);
        clear = 1'b1;                                // event and clear together
        drive(1'b0, '0, 1'b1, '0);
        clear = 1'b0;
        check("t5_unf_wins", 64'(tag_underflow), 64'd1);
        idle(3);
        check("t5_no_result", 64'(found_valid), 64'd0);

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 32'h5F, 1'b0, '0);
        drive(1'b0, '0, 1'b1, '0);
        idle(3);
        check("t6_pre_fv", 64'(found_valid), 64'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, NW'(32'h60 + i), 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check("t6_fv",        64'(found_valid),     64'd0);
        check("t6_nonce",     64'(found_nonce),     64'd0);
        check("t6_ovf",       64'(tag_overflow),    64'd0);
        check("t6_unf",       64'(tag_underflow),   64'd0);
        check("t6_dropped",   64'(results_dropped), 64'd0);
        tag_q.delete();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, '0);
        fv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (found_valid) fv_seen++;
            tick();
        end
        check("t6_post_unf", 64'(tag_underflow), 64'd1);
        check("t6_post_fv",  64'(fv_seen),       64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
